// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port between NUM_REQ pixel fetchers.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 (background) always win.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 9,
    parameter int MEM_LATENCY = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [NUM_REQ-1:0]        i_Req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_Addr,
    input  logic                      i_Flush,
    output logic [NUM_REQ-1:0]        o_Gnt,
    output logic [ADDR_W-1:0]         o_Mem_Addr,
    input  logic [DATA_W-1:0]         i_Mem_Data,
    output logic [NUM_REQ-1:0]        o_Rd_Valid,
    output logic [DATA_W-1:0]         o_Rd_Data,
    output logic                      o_Busy
);

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       ptr_next;
    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    logic                   busy_next;
    logic                   gnt_vld;
    logic [IDX_W-1:0]       gnt_id;
    logic [MEM_LATENCY-1:0] pipe_vld;
    logic [IDX_W-1:0]       pipe_id [MEM_LATENCY];

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ)
            sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Winner search: first requester at or above the pointer, wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (FIXED_PRIO && i_Req[0]) begin
            win_found = 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(ptr, k);
            if (!win_found && i_Req[cand] && !(FIXED_PRIO && cand == '0)) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        ptr_next = wrap_idx(win_idx, 1);
        if (FIXED_PRIO && win_idx == '0)
            ptr_next = ptr;
    end

    // Busy mirrors the OR of the valid bits as they will be after this edge.
    always_comb begin
        busy_next = 1'b0;
        if (!i_Flush) begin
            busy_next = win_found | gnt_vld;
            for (int s = 0; s < MEM_LATENCY - 1; s++)
                busy_next = busy_next | pipe_vld[s];
        end
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_Rst) begin
            ptr        <= '0;
            o_Gnt      <= '0;
            gnt_vld    <= 1'b0;
            o_Mem_Addr <= '0;
            pipe_vld   <= '0;
            o_Busy     <= 1'b0;
        end else begin
            for (int s = MEM_LATENCY - 1; s > 0; s--)
                pipe_vld[s] <= pipe_vld[s-1] & ~i_Flush;
            pipe_vld[0] <= gnt_vld & ~i_Flush;

            if (i_Flush || !win_found) begin
                o_Gnt   <= '0;
                gnt_vld <= 1'b0;
            end else begin
                o_Gnt      <= NUM_REQ'(1) << win_idx;
                gnt_vld    <= 1'b1;
                o_Mem_Addr <= i_Addr[int'(win_idx)*ADDR_W +: ADDR_W];
                ptr        <= ptr_next;
            end
            o_Busy <= busy_next;
        end
    end

    // NOTE: id payloads are not reset; they are only ever read when their valid bit is set.
    always_ff @(posedge i_Clk) begin
        gnt_id     <= win_idx;
        pipe_id[0] <= gnt_id;
        for (int s = MEM_LATENCY - 1; s > 0; s--)
            pipe_id[s] <= pipe_id[s-1];
    end

    always_comb begin
        o_Rd_Valid = '0;
        if (pipe_vld[MEM_LATENCY-1])
            o_Rd_Valid[pipe_id[MEM_LATENCY-1]] = 1'b1;
    end

    assign o_Rd_Data = i_Mem_Data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a latency-1 instance driven from a vector table,
// plus a latency-3 instance for the flush and reset-in-flight sequences.
module tb_sprite_rom_arbiter;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_Flush;
    logic [3:0]  i_Req;
    logic [39:0] i_Addr;

    logic [3:0]  gnt1, rdv1, gnt3, rdv3;
    logic [9:0]  maddr1, maddr3;
    logic [8:0]  mdata1, rdata1, rdata3;
    logic [8:0]  m3 [3];
    logic        busy1, busy3;

    int total = 0;
    int bad   = 0;

    always #5 i_Clk = ~i_Clk;

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(9), .MEM_LATENCY(1)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Addr(i_Addr), .i_Flush(i_Flush),
        .o_Gnt(gnt1), .o_Mem_Addr(maddr1), .i_Mem_Data(mdata1),
        .o_Rd_Valid(rdv1), .o_Rd_Data(rdata1), .o_Busy(busy1)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(9), .MEM_LATENCY(3)) dut3 (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Addr(i_Addr), .i_Flush(i_Flush),
        .o_Gnt(gnt3), .o_Mem_Addr(maddr3), .i_Mem_Data(m3[2]),
        .o_Rd_Valid(rdv3), .o_Rd_Data(rdata3), .o_Busy(busy3)
    );

    function automatic logic [8:0] rom(input logic [9:0] a);
        return 9'((int'(a) * 7 + 3) ^ (int'(a) >> 2));
    endfunction

    // Behavioural ROMs: one and three cycles from address to data.
    always @(posedge i_Clk) begin
        mdata1 <= rom(maddr1);
        m3[0]  <= rom(maddr3);
        m3[1]  <= m3[0];
        m3[2]  <= m3[1];
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       flush;
        logic [3:0] gnt;
        logic [9:0] addr;
        logic [3:0] rdv;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic flush,
                       input logic [3:0] gnt, input logic [9:0] addr, input logic [3:0] rdv,
                       input logic busy);
        vecs.push_back('{rst, req, flush, gnt, addr, rdv, busy});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req, input logic flush);
        i_Rst   = rst;
        i_Req   = req;
        i_Flush = flush;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        i_Rst   = 1'b1;
        i_Req   = '0;
        i_Flush = 1'b0;
        i_Addr  = {10'd1000, 10'd513, 10'd200, 10'd37};

        // Reset state, then a single request from requester 0.
        add(1, 4'b0000, 0, 4'b0000, 10'd0,    4'b0000, 0);
        add(0, 4'b0001, 0, 4'b0001, 10'd37,   4'b0000, 1);
        add(0, 4'b0000, 0, 4'b0000, 10'd37,   4'b0001, 1);
        add(0, 4'b0000, 0, 4'b0000, 10'd37,   4'b0000, 0);
        add(1, 4'b0000, 0, 4'b0000, 10'd0,    4'b0000, 0);
`ifndef ARB_FIXED_PRIORITY_EN
        // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
        add(0, 4'b1111, 0, 4'b0001, 10'd37,   4'b0000, 1);
        add(0, 4'b1111, 0, 4'b0010, 10'd200,  4'b0001, 1);
        add(0, 4'b1111, 0, 4'b0100, 10'd513,  4'b0010, 1);
        add(0, 4'b1111, 0, 4'b1000, 10'd1000, 4'b0100, 1);
        add(0, 4'b1111, 0, 4'b0001, 10'd37,   4'b1000, 1);
        add(0, 4'b1111, 0, 4'b0010, 10'd200,  4'b0001, 1);
        add(0, 4'b1111, 0, 4'b0100, 10'd513,  4'b0010, 1);
        add(0, 4'b1111, 0, 4'b1000, 10'd1000, 4'b0100, 1);
        // Sparse pattern 1010 from pointer 0.
        add(0, 4'b1010, 0, 4'b0010, 10'd200,  4'b1000, 1);
        add(0, 4'b1010, 0, 4'b1000, 10'd1000, 4'b0010, 1);
        add(0, 4'b1010, 0, 4'b0010, 10'd200,  4'b1000, 1);
        add(0, 4'b1010, 0, 4'b1000, 10'd1000, 4'b0010, 1);
        add(0, 4'b0000, 0, 4'b0000, 10'd1000, 4'b1000, 1);
        add(0, 4'b0000, 0, 4'b0000, 10'd1000, 4'b0000, 0);
        // Flush with a request: no grant, pointer kept; flush kills an in-flight read.
        add(0, 4'b0100, 1, 4'b0000, 10'd1000, 4'b0000, 0);
        add(0, 4'b0110, 0, 4'b0010, 10'd200,  4'b0000, 1);
        add(0, 4'b0000, 1, 4'b0000, 10'd200,  4'b0000, 0);
        add(0, 4'b0000, 0, 4'b0000, 10'd200,  4'b0000, 0);
`else
        // Requester 0 dominates; the others rotate among themselves once it drops out.
        add(0, 4'b1111, 0, 4'b0001, 10'd37,   4'b0000, 1);
        add(0, 4'b1111, 0, 4'b0001, 10'd37,   4'b0001, 1);
        add(0, 4'b1111, 0, 4'b0001, 10'd37,   4'b0001, 1);
        add(0, 4'b1111, 0, 4'b0001, 10'd37,   4'b0001, 1);
        add(0, 4'b1110, 0, 4'b0010, 10'd200,  4'b0001, 1);
        add(0, 4'b1110, 0, 4'b0100, 10'd513,  4'b0010, 1);
        add(0, 4'b1110, 0, 4'b1000, 10'd1000, 4'b0100, 1);
        add(0, 4'b1110, 0, 4'b0010, 10'd200,  4'b1000, 1);
        add(0, 4'b0000, 0, 4'b0000, 10'd200,  4'b0010, 1);
        add(0, 4'b0000, 0, 4'b0000, 10'd200,  4'b0000, 0);
`endif

        step(1, 4'b0000, 0);
        step(1, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].flush);
            check($sformatf("v%0d gnt", i),    32'(gnt1),   32'(vecs[i].gnt));
            check($sformatf("v%0d addr", i),   32'(maddr1), 32'(vecs[i].addr));
            check($sformatf("v%0d rdv", i),    32'(rdv1),   32'(vecs[i].rdv));
            check($sformatf("v%0d busy", i),   32'(busy1),  32'(vecs[i].busy));
            check($sformatf("v%0d onehot", i), 32'($onehot0(rdv1)), 32'd1);
            if (i > 0 && vecs[i].rdv != 4'b0000)
                check($sformatf("v%0d data", i), 32'(rdata1), 32'(rom(vecs[i-1].addr)));
        end

        // Latency 3: grant, then flush one cycle later; the read must never surface.
        step(1, 4'b0000, 0);
        step(0, 4'b0100, 0);
        check("l3 gnt", 32'(gnt3), 32'(4'b0100));
        check("l3 busy", 32'(busy3), 32'd1);
        step(0, 4'b0000, 1);
        check("l3 flush gnt", 32'(gnt3), 32'd0);
        check("l3 flush busy", 32'(busy3), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0000, 0);
            check($sformatf("l3 flushed rdv %0d", i), 32'(rdv3), 32'd0);
            check($sformatf("l3 flushed busy %0d", i), 32'(busy3), 32'd0);
        end

        // Pointer survived the flush (sits at 3), so 1010 picks requester 3; data after 3 cycles.
        step(0, 4'b1010, 0);
        check("l3 ptr gnt", 32'(gnt3), 32'(4'b1000));
        check("l3 ptr addr", 32'(maddr3), 32'd1000);
        for (int i = 1; i <= 4; i++) begin
            step(0, 4'b0000, 0);
            check($sformatf("l3 rdv +%0d", i), 32'(rdv3), (i == 3) ? 32'(4'b1000) : 32'd0);
            check($sformatf("l3 busy +%0d", i), 32'(busy3), (i < 4) ? 32'd1 : 32'd0);
        end
        check("l3 data", 32'(rdata3), 32'(rom(10'd1000)));

        // Reset with reads in flight: everything drops and never comes back valid.
        step(0, 4'b1111, 0);
        step(0, 4'b1111, 0);
        step(1, 4'b0000, 0);
        check("rst gnt3", 32'(gnt3), 32'd0);
        check("rst rdv3", 32'(rdv3), 32'd0);
        check("rst busy3", 32'(busy3), 32'd0);
        check("rst addr3", 32'(maddr3), 32'd0);
        check("rst gnt1", 32'(gnt1), 32'd0);
        check("rst rdv1", 32'(rdv1), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0000, 0);
            check($sformatf("post rst rdv3 %0d", i), 32'(rdv3), 32'd0);
        end
        step(0, 4'b1100, 0);
        check("post rst gnt3", 32'(gnt3), 32'(4'b0100));
        check("post rst gnt1", 32'(gnt1), 32'(4'b0100));
        check("post rst addr1", 32'(maddr1), 32'd513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
